// File: rtl/rf_scoreboard.sv
// Register file with a per-register busy (pending-write) scoreboard and 1-cycle registered reads.
// Optional macro RF_BYPASS_EN forwards same-edge write data to the read ports.
module rf_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DATA_W-1:0] rsa,
  output logic [DATA_W-1:0] rsb,
  output logic              busy_a,
  output logic              busy_b,
  output logic              rsv_err,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] rsa_q, rsa_d;
  logic [DATA_W-1:0] rsb_q, rsb_d;
  logic              busy_a_q, busy_a_d;
  logic              busy_b_q, busy_b_d;
  logic              rsv_err_q, rsv_err_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

  logic wr_ok, rsv_ok, set_new, clr_old;

  // Register 0 swallows writes and reservations when it is hardwired to zero.
  always_comb begin
    wr_ok  = wr_en;
    rsv_ok = rsv_en;
    if (ZERO_REG != 0) begin
      if (wr_addr == '0)  wr_ok  = 1'b0;
      if (rsv_addr == '0) rsv_ok = 1'b0;
    end
  end

  // Clear first, then set: a same-edge reservation wins over the write.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[wr_addr]  = 1'b0;
    if (rsv_ok) busy_d[rsv_addr] = 1'b1;
  end

  always_comb begin
    set_new   = rsv_ok && !busy_q[rsv_addr];
    clr_old   = wr_ok && busy_q[wr_addr] && !(rsv_ok && (rsv_addr == wr_addr));
    rsv_err_d = rsv_ok && busy_q[rsv_addr] && !(wr_ok && (wr_addr == rsv_addr));
    busy_cnt_d = busy_cnt_q;
    if (set_new && !clr_old)      busy_cnt_d = busy_cnt_q + (ADDR_W+1)'(1);
    else if (clr_old && !set_new) busy_cnt_d = busy_cnt_q - (ADDR_W+1)'(1);
  end

  always_comb begin
    rsa_d = mem_q[ra_addr];
    rsb_d = mem_q[rb_addr];
`ifdef RF_BYPASS_EN
    if (wr_ok && (wr_addr == ra_addr)) rsa_d = wr_data;
    if (wr_ok && (wr_addr == rb_addr)) rsb_d = wr_data;
`endif
    if ((ZERO_REG != 0) && (ra_addr == '0)) rsa_d = '0;
    if ((ZERO_REG != 0) && (rb_addr == '0)) rsb_d = '0;
    busy_a_d = busy_d[ra_addr];
    busy_b_d = busy_d[rb_addr];
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q     <= '0;
      rsa_q      <= '0;
      rsb_q      <= '0;
      busy_a_q   <= 1'b0;
      busy_b_q   <= 1'b0;
      rsv_err_q  <= 1'b0;
      busy_cnt_q <= '0;
    end else begin
      if (wr_ok) mem_q[wr_addr] <= wr_data;
      busy_q     <= busy_d;
      rsa_q      <= rsa_d;
      rsb_q      <= rsb_d;
      busy_a_q   <= busy_a_d;
      busy_b_q   <= busy_b_d;
      rsv_err_q  <= rsv_err_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign rsa      = rsa_q;
  assign rsb      = rsb_q;
  assign busy_a   = busy_a_q;
  assign busy_b   = busy_b_q;
  assign rsv_err  = rsv_err_q;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard (default parameters) with hand-computed expectations.
module tb_rf_scoreboard;

  logic        clk;
  logic        rst_f;
  logic [3:0]  ra_addr, rb_addr, wr_addr, rsv_addr;
  logic        wr_en, rsv_en;
  logic [31:0] wr_data;
  logic [31:0] rsa, rsb;
  logic        busy_a, busy_b, rsv_err;
  logic [4:0]  busy_cnt;

  int total = 0;
  int bad   = 0;

  rf_scoreboard dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsa      (rsa),
    .rsb      (rsb),
    .busy_a   (busy_a),
    .busy_b   (busy_b),
    .rsv_err  (rsv_err),
    .busy_cnt (busy_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rsv_en = 1'b0;
  endtask

  task automatic do_wr(input logic [3:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic do_rsv(input logic [3:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  logic [31:0] exp_byp;

  initial begin
    rst_f = 1'b0;
    ra_addr = '0; rb_addr = '0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
    idle();
    #2;
    chk("rst_rsa", rsa, 0);
    chk("rst_busy_cnt", busy_cnt, 0);
    chk("rst_rsv_err", rsv_err, 0);
    step(); step();
    rst_f = 1'b1;

    // write R3, then read it
    do_wr(3, 32'hDEADBEEF);
    step();
    idle(); ra_addr = 3;
    step();
    chk("r3_rsa", rsa, 32'hDEADBEEF);
    chk("r3_busy_a", busy_a, 0);
    chk("r3_cnt", busy_cnt, 0);

    // register 0 ignores writes and reservations
    do_wr(0, 32'h12345678); do_rsv(0); ra_addr = 0;
    step();
    idle();
    step();
    chk("r0_rsa", rsa, 0);
    chk("r0_cnt", busy_cnt, 0);
    chk("r0_rsv_err", rsv_err, 0);
    chk("r0_busy_a", busy_a, 0);

    // double reservation of R5
    do_rsv(5); ra_addr = 5;
    step();
    chk("r5_busy_a", busy_a, 1);
    chk("r5_cnt1", busy_cnt, 1);
    chk("r5_err0", rsv_err, 0);
    step();
    chk("r5_err1", rsv_err, 1);
    chk("r5_cnt_hold", busy_cnt, 1);
    idle();
    step();
    chk("r5_err_pulse", rsv_err, 0);
    do_wr(5, 32'h55);
    step();
    chk("r5_cnt_clr", busy_cnt, 0);
    chk("r5_busy_a_clr", busy_a, 0);
    idle();
    step();
    chk("r5_rsa", rsa, 32'h55);

    // same-edge reserve + write on busy R7
    do_rsv(7); ra_addr = 7;
    step();
    chk("r7_cnt1", busy_cnt, 1);
    do_rsv(7); do_wr(7, 32'hA5A5A5A5);
    step();
    chk("r7_busy_a", busy_a, 1);
    chk("r7_cnt_same", busy_cnt, 1);
    chk("r7_err", rsv_err, 0);
    idle();
    step();
    chk("r7_rsa", rsa, 32'hA5A5A5A5);
    chk("r7_still_busy", busy_a, 1);
    do_wr(7, 32'hA5A5A5A5);
    step();
    idle();
    chk("r7_cnt_clr", busy_cnt, 0);

    // read-during-write on R2, both ports
`ifdef RF_BYPASS_EN
    exp_byp = 32'h11;
`else
    exp_byp = 32'h0;
`endif
    do_wr(2, 32'h11); ra_addr = 2; rb_addr = 2;
    step();
    chk("r2_rsa_same", rsa, exp_byp);
    chk("r2_rsb_same", rsb, exp_byp);
    idle();
    step();
    chk("r2_rsa_next", rsa, 32'h11);
    chk("r2_rsb_next", rsb, 32'h11);

    // set one register while clearing another
    do_rsv(9);
    step();
    do_rsv(10); do_wr(9, 32'h99); ra_addr = 9; rb_addr = 10;
    step();
    chk("x_cnt", busy_cnt, 1);
    chk("x_busy_a", busy_a, 0);
    chk("x_busy_b", busy_b, 1);
    idle(); do_wr(11, 32'hBB);
    step();
    chk("idle_clr_cnt", busy_cnt, 1);
    do_wr(10, 32'hAA);
    step();
    idle();
    chk("x_cnt_clr", busy_cnt, 0);

    // reserve every register, then reset between edges
    for (int i = 1; i < 16; i++) begin
      do_rsv(4'(i));
      step();
    end
    idle(); ra_addr = 3; rb_addr = 4;
    step();
    chk("full_cnt", busy_cnt, 15);
    chk("full_rsa", rsa, 32'hDEADBEEF);
    chk("full_busy_b", busy_b, 1);
    #2;
    rst_f = 1'b0;
    #1;
    chk("arst_rsa", rsa, 0);
    chk("arst_busy_b", busy_b, 0);
    chk("arst_cnt", busy_cnt, 0);
    #3;
    rst_f = 1'b1;
    step();
    chk("post_rsa", rsa, 0);
    chk("post_busy_a", busy_a, 0);
    chk("post_cnt", busy_cnt, 0);
    do_rsv(1);
    step();
    idle();
    chk("post_rsv_cnt", busy_cnt, 1);
    chk("post_rsv_err", rsv_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32, data width of each register.
REQ-002 Parameter ADDR_W, default 4, address width; depth = 2^ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_f  input  1  reset, asynchronous, active-low.
REQ-006 ra_addr  input  ADDR_W  read port A address.
REQ-007 rb_addr  input  ADDR_W  read port B address.
REQ-008 wr_en  input  1  write enable.
REQ-009 wr_addr  input  ADDR_W  write address.
REQ-010 wr_data  input  DATA_W  write data.
REQ-011 rsv_en  input  1  reserve request; marks rsv_addr as pending-write (busy).
REQ-012 rsv_addr  input  ADDR_W  register to reserve.
REQ-013 rsa  output  DATA_W  registered read data, port A.
REQ-014 rsb  output  DATA_W  registered read data, port B.
REQ-015 busy_a  output  1  registered busy flag of ra_addr.
REQ-016 busy_b  output  1  registered busy flag of rb_addr.
REQ-017 rsv_err  output  1  one-cycle pulse: reservation hit an already-busy register (WAW).
REQ-018 busy_cnt  output  ADDR_W+1  number of registers currently busy.

Function
REQ-019 Storage SHALL be 2^ADDR_W x DATA_W flops; mem[wr_addr] <= wr_data on rising clk when wr_en=1.
REQ-020 rsa/rsb SHALL load contents of ra_addr/rb_addr on every rising clk; read latency exactly 1 cycle; no read enable.
REQ-021 ZERO_REG=1: reads of address 0 return 0; writes to 0 discarded; rsv_en on 0 ignored (no busy, no rsv_err, no count change).
REQ-022 ZERO_REG=0: register 0 behaves as any other register.
REQ-023 Scoreboard: one busy bit per register; rsv_en sets busy[rsv_addr]; wr_en clears busy[wr_addr].
REQ-024 rsv_en and wr_en same edge, same address: busy SHALL end set (new reservation wins); write data still stored.
REQ-025 busy_a/busy_b SHALL reflect post-edge busy state of ra_addr/rb_addr (same-edge set/clear included).
REQ-026 rsv_err SHALL be 1 for exactly the cycle after an edge where rsv_en targets a register already busy and not cleared by wr_en that edge; busy stays set.
REQ-027 busy_cnt SHALL track busy bits exactly: +1 on new set, -1 on clear of busy bit, unchanged on set-of-busy, clear-of-idle, or same-address set+clear; never wraps (max 2^ADDR_W).
REQ-028 wr_en to a non-busy register SHALL write data and leave busy_cnt unchanged.

Reset
REQ-029 rst_f low SHALL immediately, without clk, clear all mem entries, all busy bits, rsa, rsb, busy_a, busy_b, rsv_err, busy_cnt to 0.
REQ-030 Reset asserted mid-operation SHALL discard in-flight reservations; first edge after rst_f rises behaves as from idle.

Configuration
REQ-031 Macro RF_BYPASS_EN defined: if wr_en=1 and wr_addr equals ra_addr (or rb_addr) on an edge, rsa (rsb) SHALL load wr_data that edge (subject to REQ-021).
REQ-032 RF_BYPASS_EN undefined: same case SHALL load pre-write contents; new value visible one edge later.

Verification
REQ-033 Reset, write R3=0xDEADBEEF, next cycle ra_addr=3 -> rsa=0xDEADBEEF one cycle later, busy_a=0.
REQ-034 ZERO_REG=1: wr_en R0=0x12345678, rsv_en R0 -> rsa(R0)=0, busy_cnt=0, rsv_err=0.
REQ-035 rsv_en R5, then rsv_en R5 again -> rsv_err pulses one cycle, busy_cnt=1; wr_en R5 -> busy_cnt=0, busy_a(R5)=0.
REQ-036 Same edge rsv_en R7 and wr_en R7=0xA5A5A5A5 with R7 busy -> busy stays 1, busy_cnt unchanged, mem[7]=0xA5A5A5A5.
REQ-037 wr_en R2=0x11 with ra_addr=2 same edge (old 0) -> rsa=0x11 with RF_BYPASS_EN, rsa=0 without.
REQ-038 Reserve R1,R2,R4 (busy_cnt=3), drop rst_f between edges -> all outputs 0 immediately, busy_cnt=0.
